ext_bus_responder: RTL
======================

Name: ext_bus_responder

Overview:
- Target-side model of the SoC external bus. Sits in the sim top, on the far side of the soc external port.
- Responds to the soc initiator with a word-organised RAM, programmable wait states and a console output FIFO that the host harness drains.
- Lets firmware run off-chip memory and print characters without C++ bus modelling.

Parameters:
- ADDR_W, 16, byte-address width of the bus.
- RAM_WORDS, 4096, number of 32-bit RAM words, mapped from byte address 0.
- WAIT_STATES, 0, extra cycles inserted before ack; range 0..15.
- CON_DEPTH, 16, console FIFO depth; power of two, at least 2.
- INIT_FILE, "", hex image loaded into the RAM at elaboration when non-empty.

Ports:
- i_clk  in  1  single clock; all state is on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_ext_addr  in  ADDR_W  byte address; bits [1:0] are ignored.
- i_ext_stb  in  1  request; the initiator holds it high until ack.
- i_ext_we  in  4  byte-lane write enables; 0 means read.
- o_ext_ack  out  1  one-cycle completion pulse.
- i_ext_dat_w  in  32  write data.
- o_ext_dat_r  out  32  read data; valid in the ack cycle, held until the next read ack.
- o_con_data  out  8  console byte at the FIFO head.
- o_con_valid  out  1  FIFO not empty.
- i_con_ready  in  1  host pops a byte when valid and ready are both high.

Behaviour:
- Reset (async assert, sync release):
  - o_ext_ack=0, o_ext_dat_r=0, o_con_valid=0, o_con_data=0.
  - FSM goes to IDLE and the FIFO is emptied.
  - RAM contents are retained.
  - Reset asserted mid-transaction aborts it; no write is committed unless it completed before reset.
- Memory map:
  - RAM at 0x0000..RAM_WORDS*4-1.
  - CON_DATA at 0xFF00 (write pushes byte lane 0, write data [7:0]; read returns 0).
  - CON_STATUS at 0xFF04 (read: bit0=full, bit1=empty, bits[15:8]=level; writes ignored).
  - All other addresses: read returns 0, write is discarded, ack is still given.
- FSM states: IDLE, WAIT, STALL, ACK.
  - IDLE: when stb is sampled high, latch addr, we and data, and load wcnt=WAIT_STATES. Next state is WAIT if WAIT_STATES>0, else ACK.
  - WAIT: wcnt decrements each cycle; at wcnt==1 go to ACK.
  - Before entering ACK, a console write with the FIFO full goes to STALL instead.
  - STALL: stay until not full. The push happens on the cycle leaving STALL, then go to ACK.
  - ACK: o_ext_ack=1 for exactly one cycle; return to IDLE. Stb is not sampled in the ACK cycle.
- Latency:
  - Ack is registered, WAIT_STATES+1 cycles after stb is first sampled, plus any STALL cycles.
  - Back-to-back transactions: a new stb is accepted in the cycle after ack, so minimum throughput is one transaction per WAIT_STATES+2 cycles.
- RAM write and read timing:
  - RAM write commits on the ACK-entry edge, only for lanes with we[i]=1; we=4'b0000 is a read.
  - Read data is registered and updated only on read acks. It is unchanged by writes and by non-ack cycles.
- Console FIFO:
  - A push and a pop in the same cycle when the FIFO is full is not allowed; a full FIFO stalls the push.
  - A push and a pop in the same cycle when the FIFO is empty is not allowed; a push into an empty FIFO appears on o_con_valid the next cycle.
  - Level is unchanged when a push and a pop happen together in the non-boundary case.
  - Pointers wrap modulo CON_DEPTH.
- Address wrap: a RAM word index is addr[ADDR_W-1:2]. Addresses at or beyond RAM_WORDS are out of range, not aliased.
- A stb drop before ack is a protocol violation. The responder still completes the transaction and flags it with a sim-only assertion.

Decomposition:
- Package ext_bus_pkg:
  - CON_DATA_ADDR and CON_STATUS_ADDR constants.
  - Responder state enum.
  - BUS_DW=32 and BUS_BE_W=4.
- Sub-module sync_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, level) for the console FIFO.
- RAM and FSM stay in ext_bus_responder.

Test Plan:
- Reset, then WAIT_STATES=0: write 0x12345678 to 0x0010 with we=4'hF, then read 0x0010 → ack exactly 1 cycle after stb each time; o_ext_dat_r=0x12345678 in the read ack cycle.
- Byte lanes: 0x0010 holds 0x12345678; write 0xAABBCCDD with we=4'b0101 → read returns 0x12BB56DD.
- WAIT_STATES=3: read 0x0000 → ack 4 cycles after stb; back-to-back reads have 1 idle cycle between acks.
- Console: i_con_ready=0, write 17 bytes to 0xFF00 with CON_DEPTH=16 → 16 acks, the 17th stalls with CON_STATUS level=16. Raise ready for 1 cycle → 17th ack follows; bytes drain in order.
- Out of range: write, then read 0x8000 with RAM_WORDS=4096 → both acked; read returns 0; RAM word 0 unchanged.
- Reset asserted during WAIT of a write (WAIT_STATES=3) → ack never pulses; target word unchanged; console FIFO empty after release.

Source files
------------

// File: rtl/ext_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_bus_pkg
// Description : Shared constants, state encoding and helpers for the external
//               bus responder (sim-top target model of the SoC external port).
// Revision    : 1.0 - initial release
// ============================================================================
package ext_bus_pkg;

  localparam int unsigned BUS_DW   = 32;
  localparam int unsigned BUS_BE_W = 4;

  // Console registers, as full byte addresses
  localparam logic [31:0] CON_DATA_ADDR   = 32'h0000_FF00;
  localparam logic [31:0] CON_STATUS_ADDR = 32'h0000_FF04;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_STALL = 2'd2,
    S_ACK   = 2'd3
  } rsp_state_t;

  // CON_STATUS layout: bit0 full, bit1 empty, bits[15:8] fill level
  function automatic logic [BUS_DW-1:0] con_status_word(
    input logic       full,
    input logic       empty,
    input logic [7:0] level
  );
    return {16'h0000, level, 6'b000000, empty, full};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with fill level. Pushes into a full FIFO and
//               pops from an empty FIFO are ignored. DEPTH is a power of two,
//               so the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign level    = count;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Head is forced to zero when empty so storage needs no reset
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Data storage
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/ext_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : ext_bus_responder
// Description : Target-side model of the SoC external bus: word-organised RAM,
//               programmable wait states and a console output FIFO drained
//               by the host harness.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_bus_responder
  import ext_bus_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int RAM_WORDS   = 4096,
  parameter int WAIT_STATES = 0,
  parameter int CON_DEPTH   = 16,
  parameter     INIT_FILE   = ""
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [ADDR_W-1:0]   i_ext_addr,
  input  logic                i_ext_stb,
  input  logic [BUS_BE_W-1:0] i_ext_we,
  output logic                o_ext_ack,
  input  logic [BUS_DW-1:0]   i_ext_dat_w,
  output logic [BUS_DW-1:0]   o_ext_dat_r,
  output logic [7:0]          o_con_data,
  output logic                o_con_valid,
  input  logic                i_con_ready
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int IDX_W  = ADDR_W - 2;
  localparam int LVL_W  = $clog2(CON_DEPTH) + 1;
  localparam logic [3:0] WCNT_LOAD = 4'(WAIT_STATES);

  rsp_state_t           state;
  rsp_state_t           state_nx;
  logic                 out_of_reset;
  logic                 accept;

  logic [IDX_W-1:0]     idx_q;
  logic [BUS_BE_W-1:0]  we_q;
  logic [BUS_DW-1:0]    wdat_q;
  logic [3:0]           wcnt;

  logic [IDX_W-1:0]     cur_idx;
  logic [BUS_BE_W-1:0]  cur_we;
  logic [BUS_DW-1:0]    cur_wdat;
  logic                 cur_in_ram;
  logic                 cur_is_con_data;
  logic                 cur_is_con_stat;
  logic                 cur_con_push;

  logic                 enter_ack;
  logic                 ram_wr;
  logic                 rd_ack;
  logic [BUS_DW-1:0]    rd_value;
  logic [BUS_DW-1:0]    rdata;

  logic                 fifo_push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LVL_W-1:0]     fifo_level;

  logic [BUS_DW-1:0]    mem [RAM_WORDS];

  logic                 unused_addr_lsbs;
  assign unused_addr_lsbs = ^i_ext_addr[1:0];

  // A stb held through reset must not start a transaction (and hence commit a
  // RAM write) before the first clean edge after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) out_of_reset <= 1'b0;
    else          out_of_reset <= 1'b1;
  end

  assign accept = (state == S_IDLE) && i_ext_stb && out_of_reset;

  // Decode from the live bus in IDLE (zero-wait path), else from the latched request
  always_comb begin
    cur_idx  = idx_q;
    cur_we   = we_q;
    cur_wdat = wdat_q;
    if (state == S_IDLE) begin
      cur_idx  = i_ext_addr[ADDR_W-1:2];
      cur_we   = i_ext_we;
      cur_wdat = i_ext_dat_w;
    end
  end

  // Out-of-range word indices are not aliased into the RAM
  assign cur_in_ram      = (32'(cur_idx) < 32'(RAM_WORDS));
  assign cur_is_con_data = (32'(cur_idx) == (CON_DATA_ADDR >> 2));
  assign cur_is_con_stat = (32'(cur_idx) == (CON_STATUS_ADDR >> 2));
  assign cur_con_push    = cur_is_con_data && cur_we[0];

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0)                 state_nx = S_WAIT;
          else if (cur_con_push && fifo_full)  state_nx = S_STALL;
          else                                 state_nx = S_ACK;
        end
      end
      S_WAIT: begin
        if (wcnt == 4'd1) state_nx = (cur_con_push && fifo_full) ? S_STALL : S_ACK;
      end
      S_STALL: begin
        if (!fifo_full) state_nx = S_ACK;
      end
      S_ACK:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Every side effect of a transaction happens on the edge that enters ACK
  assign enter_ack = (state != S_ACK) && (state_nx == S_ACK);
  assign ram_wr    = enter_ack && cur_in_ram && (cur_we != '0);
  assign rd_ack    = enter_ack && (cur_we == '0);
  assign fifo_push = enter_ack && cur_con_push;

  // State register, request latch and wait counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      idx_q  <= '0;
      we_q   <= '0;
      wdat_q <= '0;
      wcnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        idx_q  <= i_ext_addr[ADDR_W-1:2];
        we_q   <= i_ext_we;
        wdat_q <= i_ext_dat_w;
        wcnt   <= WCNT_LOAD;
      end else if (state == S_WAIT && wcnt != 4'd0) begin
        wcnt <= wcnt - 4'd1;
      end
    end
  end

  // Read mux: RAM word, console status, or zero for everything else
  always_comb begin
    rd_value = '0;
    if (cur_in_ram)
      rd_value = mem[cur_idx[RAM_AW-1:0]];
    else if (cur_is_con_stat)
      rd_value = con_status_word(fifo_full, fifo_empty, 8'(fifo_level));
  end

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge i_clk) begin
    if (ram_wr) begin
      for (int b = 0; b < int'(BUS_BE_W); b++) begin
        if (cur_we[b]) mem[cur_idx[RAM_AW-1:0]][8*b +: 8] <= cur_wdat[8*b +: 8];
      end
    end
  end

  // Read data register, updated only by read acks
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    rdata <= '0;
    else if (rd_ack) rdata <= rd_value;
  end

  assign o_ext_ack   = (state == S_ACK);
  assign o_ext_dat_r = rdata;
  assign o_con_valid = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (CON_DEPTH)
  ) u_con_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (fifo_push),
    .push_data (cur_wdat[7:0]),
    .pop       (i_con_ready),
    .pop_data  (o_con_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

`ifndef SYNTHESIS
  // The initiator must hold stb until ack; the transaction completes regardless
  property p_stb_held;
    @(posedge i_clk) disable iff (!i_rst_n)
      (state == S_WAIT || state == S_STALL) |-> i_ext_stb;
  endproperty
  a_stb_held: assert property (p_stb_held)
    else $error("ext_bus_responder: stb dropped before ack");
`endif

endmodule
`default_nettype wire
